// File: rtl/griffin_linear.sv
// Griffin linear layer for t=3: y_i = x_i + (x0+x1+x2) + rc_i over GF(p), applied to
// N_LANES independent states, one lane per cycle through a two-stage pipeline.
module griffin_linear #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                STATE_SIZE    = 3,
    parameter int                N_LANES       = 13
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             enable,
    input  logic [STATE_SIZE-1:0][N_LANES-1:0][N_BITS-1:0]   inState,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]                rc,
    output logic [STATE_SIZE-1:0][N_LANES-1:0][N_BITS-1:0]   outState,
    output logic                                             done
);

    localparam int             CW   = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N_LANES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [STATE_SIZE-1:0][N_LANES-1:0][N_BITS-1:0] x_reg;
    logic [STATE_SIZE-1:0][N_BITS-1:0]              rc_reg;
    logic [CW-1:0]                                  lane_cnt;

    logic [STATE_SIZE-1:0][N_BITS-1:0]              lane_x;
    logic [N_BITS-1:0]                              lane_sum;

    logic                                           s1_vld;
    logic [N_BITS-1:0]                              s1_sum;
    logic [STATE_SIZE-1:0][N_BITS-1:0]              s1_x;
    logic [CW-1:0]                                  s1_idx;
    logic [STATE_SIZE-1:0][N_BITS-1:0]              y;

    // Operands are already reduced, so the sum is below 2p and one subtraction suffices.
    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [N_BITS:0] sum;
        logic [N_BITS:0] diff;
        sum  = {1'b0, a} + {1'b0, b};
        diff = sum - {1'b0, PRIME_MODULUS};
        return (sum >= {1'b0, PRIME_MODULUS}) ? diff[N_BITS-1:0] : sum[N_BITS-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = LOAD;
            LOAD:    state_next = COMPUTE;
            COMPUTE: if (lane_cnt == LAST) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 0: select the issuing lane and fold its three elements into s.
    always_comb begin
        lane_x   = '0;
        lane_sum = '0;
        for (int i = 0; i < STATE_SIZE; i++) lane_x[i] = x_reg[i][lane_cnt];
        lane_sum = lane_x[0];
        for (int i = 1; i < STATE_SIZE; i++) lane_sum = mod_add(lane_sum, lane_x[i]);
    end

    // Stage 1 result: circulant row plus round constant.
    always_comb begin
        y = '0;
        for (int i = 0; i < STATE_SIZE; i++) y[i] = mod_add(mod_add(s1_x[i], s1_sum), rc_reg[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            x_reg    <= '0;
            rc_reg   <= '0;
            lane_cnt <= '0;
            s1_vld   <= 1'b0;
            s1_sum   <= '0;
            s1_x     <= '0;
            s1_idx   <= '0;
            outState <= '0;
        end else begin
            done   <= (state_next == DONE);
            s1_vld <= (state == COMPUTE);

            if (state == LOAD) begin
                x_reg    <= inState;
                rc_reg   <= rc;
                lane_cnt <= '0;
            end else if (state == COMPUTE && lane_cnt != LAST) begin
                lane_cnt <= lane_cnt + 1'b1;
            end

            if (state == COMPUTE) begin
                s1_sum <= lane_sum;
                s1_x   <= lane_x;
                s1_idx <= lane_cnt;
            end

            if (s1_vld) begin
                for (int i = 0; i < STATE_SIZE; i++) outState[i][s1_idx] <= y[i];
            end
        end
    end

endmodule

// File: tb/tb_griffin_linear.sv
// Directed + randomized bench for griffin_linear; reference uses plain wide-integer mod p.
module tb_griffin_linear;

    localparam int NB = 254;
    localparam int T  = 3;
    localparam int NL = 13;
    localparam logic [259:0] P   = 260'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [NB-1:0] PN = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [T-1:0][NL-1:0][NB-1:0] in_st = '0;
    logic [T-1:0][NB-1:0]         rc_v  = '0;
    logic [T-1:0][NL-1:0][NB-1:0] out_st;
    logic                         done;

    logic [T-1:0][NL-1:0][NB-1:0] exp_st;
    logic [T-1:0][NL-1:0][NB-1:0] held;
    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;

    griffin_linear dut (
        .clk(clk), .reset(reset), .enable(enable),
        .inState(in_st), .rc(rc_v), .outState(out_st), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [NB-1:0] rnd_fe();
        logic [259:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = (v << 32) | 260'($urandom);
        return NB'(v % P);
    endfunction

    task automatic rnd_inputs();
        for (int i = 0; i < T; i++) begin
            rc_v[i] = rnd_fe();
            for (int j = 0; j < NL; j++) in_st[i][j] = rnd_fe();
        end
    endtask

    // y_i = (x_i + ((x0+x1+x2) mod p) + rc_i) mod p, evaluated in 260-bit integers
    task automatic build_expected();
        logic [259:0] s;
        for (int j = 0; j < NL; j++) begin
            s = (260'(in_st[0][j]) + 260'(in_st[1][j]) + 260'(in_st[2][j])) % P;
            for (int i = 0; i < T; i++)
                exp_st[i][j] = NB'((260'(in_st[i][j]) + s + 260'(rc_v[i])) % P);
        end
    endtask

    task automatic run_call(input string tag, input bit scramble);
        bit early;
        build_expected();
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;          // E0
        early = done;
        @(posedge clk); #1;                        // E0+1: LOAD captured
        if (scramble) rnd_inputs();
        if (done) early = 1'b1;
        for (int k = 2; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done) early = 1'b1;
        end
        chk({tag, "_done_early"}, 260'(early), 260'(0));
        @(posedge clk); #1;                        // E0+15
        chk({tag, "_done_rise"}, 260'(done), 260'(1));
        for (int j = 0; j < NL; j++)
            for (int i = 0; i < T; i++)
                chk($sformatf("%s_y%0d_lane%0d", tag, i, j), 260'(out_st[i][j]), 260'(exp_st[i][j]));
        @(posedge clk); #1;                        // E0+16
        chk({tag, "_done_fall"}, 260'(done), 260'(0));
    endtask

    initial begin
        int t_first;
        int t_second;
        bit seen;
        bit bad;

        #2;
        chk("reset_out_zero", 260'(out_st == '0), 260'(1));
        chk("reset_done", 260'(done), 260'(0));
        @(negedge clk); reset = 1'b0;

        // all zero
        in_st = '0; rc_v = '0;
        run_call("zero", 1'b0);

        // (1,2,3), rc 0 -> (7,8,9)
        for (int j = 0; j < NL; j++) begin
            in_st[0][j] = 254'd1; in_st[1][j] = 254'd2; in_st[2][j] = 254'd3;
        end
        rc_v = '0;
        run_call("small", 1'b0);
        chk("small_const_y0", 260'(out_st[0][0]), 260'd7);
        chk("small_const_y2", 260'(out_st[2][NL-1]), 260'd9);

        // p-1 everywhere, rc 1 -> p-3
        for (int j = 0; j < NL; j++)
            for (int i = 0; i < T; i++) in_st[i][j] = PN - 254'd1;
        for (int i = 0; i < T; i++) rc_v[i] = 254'd1;
        run_call("wrap", 1'b0);
        chk("wrap_const", 260'(out_st[1][6]), 260'(PN - 254'd3));

        // lane 0 hits sum == p exactly
        rnd_inputs();
        in_st[0][0] = PN - 254'd1; in_st[1][0] = 254'd1; in_st[2][0] = 254'd0;
        rc_v = '0;
        run_call("sum_eq_p", 1'b0);
        chk("sum_eq_p_y0", 260'(out_st[0][0]), 260'(PN - 254'd1));

        // inputs scrambled right after LOAD
        rnd_inputs();
        run_call("rand_scr", 1'b1);

        // outputs must hold in IDLE while inputs move
        held = out_st;
        rnd_inputs();
        repeat (4) @(posedge clk);
        #1 chk("idle_hold", 260'(out_st == held), 260'(1));

        rnd_inputs();
        run_call("rand2", 1'b0);

        // reset during lane 5 issue
        rnd_inputs();
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;          // E0
        repeat (7) @(posedge clk);                 // E0+7: lane 5 issued
        #2 reset = 1'b1;
        #1;
        chk("abort_out_zero", 260'(out_st == '0), 260'(1));
        chk("abort_done", 260'(done), 260'(0));
        @(negedge clk); reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) bad = 1'b1;
        end
        chk("abort_no_done", 260'(bad), 260'(0));

        rnd_inputs();
        run_call("post_reset", 1'b0);

        // enable held high: done period
        @(negedge clk); enable = 1'b1;
        seen = 1'b0; t_first = 0; t_second = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; t_first = cyc; end
        end
        chk("period_first_seen", 260'(seen), 260'(1));
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; t_second = cyc; end
        end
        chk("period_second_seen", 260'(seen), 260'(1));
        chk("done_period", 260'(t_second - t_first), 260'd17);
        enable = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
